magnetron_cycle_ctrl: RTL and testbench

- Sequential cooking-cycle controller that drives the magnetron enable for the microwave.
- Latches a cook time and power level, then counts seconds down.
- Duty-cycles the magnetron inside a fixed window according to power level.
- Handles pause/resume/cancel, door interlock and end-of-cycle beep. Sits between the keypad/timebase and the magnetron drive.

---
 rtl/microwave_pkg.sv | 20 ++
 rtl/btn_press_detect.sv | 27 ++
 rtl/magnetron_cycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_magnetron_cycle_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cooking-cycle controller.
//   state_t         : controller states
//   POWER_MAX       : highest power level; also the value out-of-range levels map to
//   DUTY_PERIOD_DEF : default duty window length in seconds
//   PHASE_W         : width of the duty-window phase counter
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        COOK,
        PAUSE,
        DONE
    } state_t;

    localparam int POWER_MAX       = 10;
    localparam int DUTY_PERIOD_DEF = 10;
    localparam int PHASE_W         = 4;

endpackage

// File: rtl/btn_press_detect.sv
// Falling-edge press detector for an active-low push button.
//   clk   : system clock
//   reset : synchronous active-high reset; presets the history to "released"
//   btn_n : active-low button level
//   press : high in the cycle where the button goes from released to pressed
// The history register holds the previous sample, so a held button yields a
// single press and the press is visible on the same clock edge that samples it.
module btn_press_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    logic hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 1'b1;
        end else begin
            hist <= btn_n;
        end
    end

    assign press = hist & ~btn_n;

endmodule

// File: rtl/magnetron_cycle_ctrl.sv
// Cooking-cycle controller driving the magnetron enable.
//   clk, reset            : clock, synchronous active-high reset
//   startn/stopn/clearn   : active-low button levels (edge-detected internally)
//   door_closed           : door interlock, 1 = closed
//   sec_tick              : one-cycle pulse per second
//   load, time_in, power_in : latch a cook time (s) and power level (1..10)
//   mag_on                : magnetron enable, duty-cycled by power level
//   time_left             : remaining cook seconds
//   cooking, paused       : state indicators
//   done                  : one-cycle pulse on completion
//   beep                  : buzzer enable while in the completion state
module magnetron_cycle_ctrl
    import microwave_pkg::*;
#(
    parameter int TIME_W         = 12,
    parameter int DUTY_PERIOD    = DUTY_PERIOD_DEF,
    parameter int DONE_BEEP_SECS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              sec_tick,
    input  logic              load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [3:0]        power_in,
    output logic              mag_on,
    output logic [TIME_W-1:0] time_left,
    output logic              cooking,
    output logic              paused,
    output logic              done,
    output logic              beep
);

    localparam int                 BC_W       = (DONE_BEEP_SECS > 1) ? $clog2(DONE_BEEP_SECS) : 1;
    localparam logic [BC_W-1:0]    BC_LAST    = BC_W'(DONE_BEEP_SECS - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DUTY_PERIOD - 1);

    // Levels of 0 or above the maximum are treated as full power.
    function automatic logic [3:0] sat_power(input logic [3:0] p);
        if (p == 4'd0 || p > 4'(POWER_MAX)) begin
            return 4'(POWER_MAX);
        end
        return p;
    endfunction

    logic start_p, stop_p, clear_p;

    btn_press_detect u_start (.clk(clk), .reset(reset), .btn_n(startn), .press(start_p));
    btn_press_detect u_stop  (.clk(clk), .reset(reset), .btn_n(stopn),  .press(stop_p));
    btn_press_detect u_clear (.clk(clk), .reset(reset), .btn_n(clearn), .press(clear_p));

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [3:0]          power_q, power_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic                done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            time_q  <= '0;
            power_q <= 4'(POWER_MAX);
            phase_q <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            power_q <= power_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_d;
        end
    end

    // Each branch chain follows event priority: clear, door, stop, start, load, tick.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        power_d = power_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load && time_in != '0) begin
                    state_d = SET;
                    time_d  = time_in;
                    power_d = sat_power(power_in);
                end
            end
            SET: begin
                if (clear_p) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (start_p && door_closed) begin
                    state_d = COOK;
                    phase_d = '0;
                end else if (load && time_in != '0) begin
                    time_d  = time_in;
                    power_d = sat_power(power_in);
                end
            end
            COOK: begin
                if (clear_p) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (!door_closed || stop_p) begin
                    state_d = PAUSE;
                end else if (sec_tick && time_q != '0) begin
                    time_d  = time_q - TIME_W'(1);
                    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
                    if (time_q == TIME_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        bcnt_d  = '0;
                    end
                end
            end
            PAUSE: begin
                if (clear_p || stop_p) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (start_p && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (clear_p || !door_closed || stop_p || start_p) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    if (bcnt_q == BC_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = '0;
            end
        endcase
    end

    // Door interlock gates the enable combinationally so opening cuts power at once.
    assign mag_on    = (state_q == COOK) && (phase_q < power_q) && door_closed;
    assign time_left = time_q;
    assign cooking   = (state_q == COOK);
    assign paused    = (state_q == PAUSE);
    assign done      = done_q;
    assign beep      = (state_q == DONE);

endmodule

// File: tb/tb_magnetron_cycle_ctrl.sv
module tb_magnetron_cycle_ctrl;

    localparam int TIME_W = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic              door_closed = 1'b1;
    logic              sec_tick = 1'b0, load = 1'b0;
    logic [TIME_W-1:0] time_in = '0;
    logic [3:0]        power_in = '0;
    logic              mag_on, cooking, paused, done, beep;
    logic [TIME_W-1:0] time_left;

    magnetron_cycle_ctrl #(.TIME_W(TIME_W), .DUTY_PERIOD(10), .DONE_BEEP_SECS(3)) dut (
        .clk(clk), .reset(reset), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .sec_tick(sec_tick), .load(load),
        .time_in(time_in), .power_in(power_in), .mag_on(mag_on), .time_left(time_left),
        .cooking(cooking), .paused(paused), .done(done), .beep(beep)
    );

    always #5 clk = ~clk;

    // Flag vectors: {mag_on, cooking, paused, done, beep}
    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_CKON  = 5'b11000;
    localparam logic [4:0] F_CKOFF = 5'b01000;
    localparam logic [4:0] F_PAUSE = 5'b00100;
    localparam logic [4:0] F_DONE  = 5'b00011;
    localparam logic [4:0] F_BEEP  = 5'b00001;

    typedef struct {
        string             tag;
        logic [4:0]        flags;
        logic [TIME_W-1:0] tl;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Queue the expectation, let one clock edge pass, then score the DUT output.
    task automatic edge_check(input string tag, input logic [4:0] ef, input logic [TIME_W-1:0] etl);
        exp_t e;
        sb.push_back('{tag, ef, etl});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_flags"}, 32'({mag_on, cooking, paused, done, beep}), 32'(e.flags));
        chk({e.tag, "_tl"}, 32'(time_left), 32'(e.tl));
    endtask

    task automatic cyc(input string tag, input bit s, input bit p, input bit c,
                       input bit l, input bit t, input logic [TIME_W-1:0] ti,
                       input logic [3:0] pi, input logic [4:0] ef, input logic [TIME_W-1:0] etl);
        startn = ~s; stopn = ~p; clearn = ~c;
        load = l; sec_tick = t; time_in = ti; power_in = pi;
        edge_check(tag, ef, etl);
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        load = 1'b0; sec_tick = 1'b0;
    endtask

    int on_secs;

    initial begin
        // Reset state
        #1;
        edge_check("rst", F_IDLE, 12'd0);
        reset = 1'b0;

        // 1: full power, 5 s, completion and beep
        cyc("t1_load", 0,0,0,1,0, 12'd5, 4'd10, F_IDLE, 12'd5);
        cyc("t1_start", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd5);
        for (int i = 1; i <= 5; i++)
            cyc("t1_tick", 0,0,0,0,1, 12'd0, 4'd0, (i < 5) ? F_CKON : F_DONE, 12'(5 - i));
        cyc("t1_beep0", 0,0,0,0,0, 12'd0, 4'd0, F_BEEP, 12'd0);
        cyc("t1_beep1", 0,0,0,0,1, 12'd0, 4'd0, F_BEEP, 12'd0);
        cyc("t1_beep2", 0,0,0,0,1, 12'd0, 4'd0, F_BEEP, 12'd0);
        cyc("t1_beep3", 0,0,0,0,1, 12'd0, 4'd0, F_IDLE, 12'd0);

        // 2: power 3 over two duty windows
        cyc("t2_load", 0,0,0,1,0, 12'd20, 4'd3, F_IDLE, 12'd20);
        cyc("t2_start", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd20);
        on_secs = int'(mag_on);
        for (int i = 1; i <= 20; i++) begin
            cyc("t2_tick", 0,0,0,0,1, 12'd0, 4'd0,
                (i == 20) ? F_DONE : (((i % 10) < 3) ? F_CKON : F_CKOFF), 12'(20 - i));
            if (i < 20) on_secs += int'(mag_on);
        end
        chk("t2_on_secs", 32'(on_secs), 32'd6);
        cyc("t2_clear_done", 0,0,1,0,0, 12'd0, 4'd0, F_IDLE, 12'd0);

        // 3: door open mid-cook pauses and resume keeps the phase
        cyc("t3_load", 0,0,0,1,0, 12'd10, 4'd4, F_IDLE, 12'd10);
        cyc("t3_start", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd10);
        for (int i = 1; i <= 3; i++)
            cyc("t3_tick", 0,0,0,0,1, 12'd0, 4'd0, F_CKON, 12'(10 - i));
        door_closed = 1'b0;
        #1;
        chk("t3_mag_drop", 32'({mag_on, cooking}), 32'(2'b01));
        cyc("t3_pause", 0,0,0,0,0, 12'd0, 4'd0, F_PAUSE, 12'd7);
        cyc("t3_ptick1", 0,0,0,0,1, 12'd0, 4'd0, F_PAUSE, 12'd7);
        cyc("t3_ptick2", 0,0,0,0,1, 12'd0, 4'd0, F_PAUSE, 12'd7);
        door_closed = 1'b1;
        cyc("t3_closed", 0,0,0,0,0, 12'd0, 4'd0, F_PAUSE, 12'd7);
        cyc("t3_resume", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd7);
        cyc("t3_phase4", 0,0,0,0,1, 12'd0, 4'd0, F_CKOFF, 12'd6);

        // 4: stop pauses, second stop cancels; stop beats a same-cycle tick
        cyc("t4_stop1", 0,1,0,0,0, 12'd0, 4'd0, F_PAUSE, 12'd6);
        cyc("t4_gap", 0,0,0,0,0, 12'd0, 4'd0, F_PAUSE, 12'd6);
        cyc("t4_stop2", 0,1,0,0,0, 12'd0, 4'd0, F_IDLE, 12'd0);
        cyc("t4_load", 0,0,0,1,0, 12'd9, 4'd10, F_IDLE, 12'd9);
        cyc("t4_start", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd9);
        cyc("t4_stop_tick", 0,1,0,0,1, 12'd0, 4'd0, F_PAUSE, 12'd9);
        cyc("t4_restart", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd9);
        cyc("t4_clear", 0,0,1,0,0, 12'd0, 4'd0, F_IDLE, 12'd0);

        // 5: start with door open ignored; power 0 acts as 10; zero load ignored
        door_closed = 1'b0;
        cyc("t5_load", 0,0,0,1,0, 12'd12, 4'd0, F_IDLE, 12'd12);
        cyc("t5_start_open", 1,0,0,0,0, 12'd0, 4'd0, F_IDLE, 12'd12);
        door_closed = 1'b1;
        cyc("t5_gap", 0,0,0,0,0, 12'd0, 4'd0, F_IDLE, 12'd12);
        cyc("t5_start", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd12);
        for (int i = 1; i <= 9; i++)
            cyc("t5_tick", 0,0,0,0,1, 12'd0, 4'd0, F_CKON, 12'(12 - i));
        cyc("t5_clear", 0,0,1,0,0, 12'd0, 4'd0, F_IDLE, 12'd0);
        cyc("t5_load0", 0,0,0,1,0, 12'd0, 4'd5, F_IDLE, 12'd0);
        cyc("t5_start_idle", 1,0,0,0,0, 12'd0, 4'd0, F_IDLE, 12'd0);

        // 6: reset mid-cook; start held low across reset release
        cyc("t6_load", 0,0,0,1,0, 12'd100, 4'd10, F_IDLE, 12'd100);
        cyc("t6_start", 1,0,0,0,0, 12'd0, 4'd0, F_CKON, 12'd100);
        reset = 1'b1;
        startn = 1'b0;
        edge_check("t6_reset", F_IDLE, 12'd0);
        reset = 1'b0;
        edge_check("t6_post_rst", F_IDLE, 12'd0);
        load = 1'b1; time_in = 12'd8; power_in = 4'd10;
        edge_check("t6_load_held", F_IDLE, 12'd8);
        load = 1'b0;
        edge_check("t6_held1", F_IDLE, 12'd8);
        edge_check("t6_held2", F_IDLE, 12'd8);
        startn = 1'b1;
        edge_check("t6_release", F_IDLE, 12'd8);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
